// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_ctrl
// Brief    : UART transmit sequencer. Captures a word on Send+BaudTick and
//            serialises start bit, LSB-first data, optional parity and stop
//            bit(s), one bit per BaudTick. DoneFlag pulses at frame end.
// Options  : define UART_TX_PARITY_EN to insert the parity bit
//            (ParityType 0 = even, 1 = odd); otherwise ParityType is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic                 BaudTick,
  input  logic                 Send,
  input  logic [DATA_BITS-1:0] DataIn,
  input  logic                 ParityType,
  output logic                 TxOut,
  output logic                 Busy,
  output logic                 DoneFlag
);

  localparam int               CNT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic                 stop_q,  stop_d;   // set once the first of two stop bits has elapsed
  logic                 tx_q,    tx_d;
  logic                 busy_q,  busy_d;
  logic                 done_q,  done_d;
  logic                 last_stop;

`ifdef UART_TX_PARITY_EN
  // Parity is resolved at capture time because the shift register is
  // consumed as the data bits go out.
  logic                 par_q,   par_d;
`else
  logic                 unused_parity_type;
  assign unused_parity_type = ParityType;
`endif

  assign last_stop = (STOP_BITS == 1) || stop_q;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    stop_d  = stop_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (BaudTick && Send) begin
          shift_d = DataIn;
`ifdef UART_TX_PARITY_EN
          par_d   = (^DataIn) ^ ParityType;
`endif
          state_d = S_START;
        end
      end
      S_START: begin
        if (BaudTick) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (BaudTick) begin
          shift_d = shift_q >> 1;
          if (cnt_q == LAST_BIT) begin
            cnt_d  = '0;
            stop_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (BaudTick) begin
          stop_d  = 1'b0;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (BaudTick) begin
          if (last_stop) begin
            stop_d  = 1'b0;
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // State and output registers, cleared asynchronously to an idle line
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign TxOut    = tx_q;
  assign Busy     = busy_q;
  assign DoneFlag = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_ctrl
// Brief    : Self-checking bench for uart_tx_ctrl. Two instances (8N1-style
//            and 6-data/2-stop) share stimulus; a frame-level model predicts
//            every output on every cycle, and directed frames pin the model
//            against hand-computed bit patterns.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
  localparam logic [15:0] EXP_EVEN_A5 = {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0};
  localparam logic [15:0] EXP_ODD_A5  = {5'b0, 1'b1, 1'b1, 8'hA5, 1'b0};
  localparam logic [15:0] EXP_FF      = {5'b0, 1'b1, 1'b0, 8'hFF, 1'b0};
  localparam logic [15:0] EXP_C3      = {5'b0, 1'b1, 1'b0, 8'hC3, 1'b0};
`else
  localparam int P = 0;
  localparam logic [15:0] EXP_EVEN_A5 = {6'b0, 1'b1, 8'hA5, 1'b0};
  localparam logic [15:0] EXP_ODD_A5  = {6'b0, 1'b1, 8'hA5, 1'b0};
  localparam logic [15:0] EXP_FF      = {6'b0, 1'b1, 8'hFF, 1'b0};
  localparam logic [15:0] EXP_C3      = {6'b0, 1'b1, 8'hC3, 1'b0};
`endif

  localparam int NB_A   = 8;
  localparam int NS_A   = 1;
  localparam int NB_B   = 6;
  localparam int NS_B   = 2;
  localparam int FLEN_A = 1 + NB_A + P + NS_A;
  localparam int FLEN_B = 1 + NB_B + P + NS_B;
  localparam int MAXLEN = (FLEN_A > FLEN_B) ? FLEN_A : FLEN_B;

  logic       Clock      = 1'b0;
  logic       ResetN     = 1'b0;
  logic       BaudTick   = 1'b0;
  logic       Send       = 1'b0;
  logic       ParityType = 1'b0;
  logic [7:0] DataIn     = 8'h00;
  logic       tx_a, busy_a, done_a, tx_b, busy_b, done_b;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  always #5 Clock = ~Clock;

  uart_tx_ctrl #(.DATA_BITS(NB_A), .STOP_BITS(NS_A)) dut_a (
    .Clock(Clock), .ResetN(ResetN), .BaudTick(BaudTick), .Send(Send),
    .DataIn(DataIn), .ParityType(ParityType),
    .TxOut(tx_a), .Busy(busy_a), .DoneFlag(done_a)
  );

  uart_tx_ctrl #(.DATA_BITS(NB_B), .STOP_BITS(NS_B)) dut_b (
    .Clock(Clock), .ResetN(ResetN), .BaudTick(BaudTick), .Send(Send),
    .DataIn(DataIn[NB_B-1:0]), .ParityType(ParityType),
    .TxOut(tx_b), .Busy(busy_b), .DoneFlag(done_b)
  );

  logic  d_tx[2], d_busy[2], d_done[2];
  string nm[2] = '{"a", "b"};
  assign d_tx[0] = tx_a;   assign d_busy[0] = busy_a;   assign d_done[0] = done_a;
  assign d_tx[1] = tx_b;   assign d_busy[1] = busy_b;   assign d_done[1] = done_b;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // A frame is a list of line levels, LSB first: start, data, [parity], stops.
  function automatic logic [15:0] build_frame(input logic [7:0] d, input logic pt, input int nb);
    logic [15:0] f;
    logic        par;
    f    = 16'hFFFF;
    f[0] = 1'b0;
    par  = pt;
    for (int i = 0; i < nb; i++) begin
      f[i+1] = d[i];
      par    = par ^ d[i];
    end
    if (P == 1) f[nb+1] = par;
    return f;
  endfunction

  logic        m_busy[2];
  logic        m_done[2];
  logic [15:0] m_bits[2];
  int          m_rem[2];

  always @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k] <= 1'b0;
        m_done[k] <= 1'b0;
        m_bits[k] <= 16'hFFFF;
        m_rem[k]  <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_done[k] <= 1'b0;
        if (!m_busy[k]) begin
          if (Send && BaudTick) begin
            m_busy[k] <= 1'b1;
            m_bits[k] <= build_frame(DataIn, ParityType, (k == 0) ? NB_A : NB_B);
            m_rem[k]  <= (k == 0) ? FLEN_A : FLEN_B;
          end
        end else if (BaudTick) begin
          if (m_rem[k] == 1) begin
            m_busy[k] <= 1'b0;
            m_done[k] <= 1'b1;
          end
          m_bits[k] <= m_bits[k] >> 1;
          m_rem[k]  <= m_rem[k] - 1;
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge Clock) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk({"tx_", nm[k]},   32'(d_tx[k]),   32'(m_busy[k] ? m_bits[k][0] : 1'b1));
        chk({"busy_", nm[k]}, 32'(d_busy[k]), 32'(m_busy[k]));
        chk({"done_", nm[k]}, 32'(d_done[k]), 32'(m_done[k]));
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  logic s_tx_a, s_busy_a, s_done_a, s_busy_b, s_done_b;

  // One BaudTick cycle, outputs sampled just after the consuming edge,
  // then 'gap' tick-free cycles. Entered and left at posedge+2.
  task automatic tick(input int gap);
    BaudTick = 1'b1;
    @(posedge Clock);
    #1;
    s_tx_a   = tx_a;
    s_busy_a = busy_a;
    s_done_a = done_a;
    s_busy_b = busy_b;
    s_done_b = done_b;
    #1 BaudTick = 1'b0;
    repeat (gap) begin
      @(posedge Clock);
      #2;
    end
  endtask

  task automatic run_frame(input string name, input logic [7:0] d, input logic p,
                           input logic [15:0] exp_a, input int mid_j);
    logic [15:0] got;
    int first_a, first_b, cnt_a, cnt_b;
    got = 16'h0; first_a = -1; first_b = -1; cnt_a = 0; cnt_b = 0;
    DataIn = d; ParityType = p; Send = 1'b1;
    tick(2);
    got[0] = s_tx_a;
    Send   = 1'b0;
    for (int j = 1; j <= MAXLEN + 3; j++) begin
      if (j == mid_j) begin
        Send = 1'b1; DataIn = 8'h3C; ParityType = ~p;
      end else if (j == mid_j + 1) begin
        Send = 1'b0;
      end
      tick(2);
      if (j < 16) got[j] = s_tx_a;
      if (s_done_a) begin cnt_a++; if (first_a < 0) first_a = j; end
      if (s_done_b) begin cnt_b++; if (first_b < 0) first_b = j; end
    end
    chk({name, " bits_a"},   32'(got[FLEN_A-1:0]), 32'(exp_a[FLEN_A-1:0]));
    chk({name, " done_at_a"}, first_a, FLEN_A);
    chk({name, " done_at_b"}, first_b, FLEN_B);
    chk({name, " done_cnt"},  32'({cnt_a[3:0], cnt_b[3:0]}), 32'h11);
    chk({name, " idle_after"}, 32'({s_busy_a, s_busy_b}), 32'h0);
  endtask

  initial begin
    int da;
    logic [15:0] got2;

    repeat (3) @(posedge Clock);
    #2;
    chk("reset_state", 32'({tx_a, busy_a, done_a, tx_b, busy_b, done_b}), 32'b100100);
    ResetN = 1'b1;
    chk_en = 1'b1;
    @(posedge Clock);
    #2;

    // Idle line with no request
    for (int i = 0; i < 20; i++) begin
      tick(2);
      if (i == 0 || i == 19)
        chk("idle", 32'({s_tx_a, s_busy_a, s_done_a, s_busy_b, s_done_b}), 32'b10000);
    end

    run_frame("even_a5", 8'hA5, 1'b0, EXP_EVEN_A5, -1);
    run_frame("odd_a5_mid", 8'hA5, 1'b1, EXP_ODD_A5, 4);

    // Back-to-back: Send held, new word presented when DoneFlag fires
    DataIn = 8'h5A; ParityType = 1'b0; Send = 1'b1;
    tick(2);
    da   = -1;
    got2 = 16'h0;
    for (int j = 1; j <= 2 * FLEN_A + 2; j++) begin
      tick(2);
      if (da >= 0 && j > da && j - da - 1 < 16) got2[j-da-1] = s_tx_a;
      if (da >= 0 && j == da + 1)
        chk("b2b_start_after_gap", 32'({s_tx_a, s_busy_a}), 32'b01);
      if (s_done_a && da < 0) begin
        da = j;
        chk("b2b_gap_idle", 32'({s_tx_a, s_busy_a}), 32'b10);
        DataIn = 8'hC3;
      end
    end
    chk("b2b_first_done", da, FLEN_A);
    chk("b2b_second_bits", 32'(got2[FLEN_A-1:0]), 32'(EXP_C3[FLEN_A-1:0]));
    Send = 1'b0;
    for (int j = 0; j < MAXLEN + 2; j++) tick(2);
    chk("b2b_drained", 32'({s_busy_a, s_busy_b}), 32'h0);

    // Reset during DATA bit 3 (0x96 bit 3 is 0, so the line visibly jumps high)
    DataIn = 8'h96; Send = 1'b1;
    tick(2);
    Send = 1'b0;
    for (int j = 1; j <= 4; j++) tick(2);
    chk("pre_reset_bit3", 32'({s_tx_a, s_busy_a}), 32'b01);
    #1 ResetN = 1'b0;
    #1 chk("async_reset", 32'({tx_a, busy_a, done_a, tx_b, busy_b, done_b}), 32'b100100);
    repeat (3) @(posedge Clock);
    #2 ResetN = 1'b1;
    repeat (2) @(posedge Clock);
    #2;
    run_frame("ff_after_reset", 8'hFF, 1'b0, EXP_FF, -1);

    // Randomised traffic, including consecutive ticks and stray resets
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 3) == 0) DataIn = 8'($urandom);
      if ($urandom_range(0, 7) == 0) ParityType = ~ParityType;
      if ($urandom_range(0, 4) == 0) Send = ~Send;
      if ($urandom_range(0, 199) == 0) begin
        #1 ResetN = 1'b0;
        @(posedge Clock);
        #2 ResetN = 1'b1;
      end
      tick($urandom_range(0, 3));
    end

    Send = 1'b0;
    for (int i = 0; i < MAXLEN + 4; i++) tick(1);
    chk("final_idle", 32'({s_busy_a, s_busy_b}), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Transmit sequencer for the UART Tx path. It accepts a send request and captures the word presented by the Tx holding register. It then serialises that word as an asynchronous frame: start bit, LSB-first data, optional parity, stop bit(s). Every bit is paced by an external baud-rate tick. At frame end it pulses `DoneFlag`, which loads the next word into the holding register and signals completion upstream.

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal range 5–8.
- `STOP_BITS`, default 1: stop bits per frame; legal values 1 or 2.

- `Clock`  in  1  system clock; all state changes on rising edge.
- `ResetN`  in  1  asynchronous, active-low reset.
- `BaudTick`  in  1  one-`Clock`-cycle pulse, once per bit period.
- `Send`  in  1  level transmit request; sampled only in IDLE.
- `DataIn`  in  DATA_BITS  word from the holding register; sampled at frame start.
- `ParityType`  in  1  0 = even, 1 = odd; sampled at frame start.
- `TxOut`  out  1  serial line; idle high.
- `Busy`  out  1  high from frame start until return to IDLE.
- `DoneFlag`  out  1  one-cycle pulse at the end of the last stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- **IDLE**
  - `TxOut`=1, `Busy`=0.
  - On a cycle with `Send`=1 and `BaudTick`=1:
    - capture `DataIn` into the shift register and `ParityType` into the parity-select flop;
    - go to START.
  - `Send` without `BaudTick` has no effect; the requester holds `Send` until `Busy` rises.
- **START**
  - `TxOut`=0.
  - On `BaudTick`: go to DATA with bit counter = 0.
- **DATA**
  - `TxOut` = shift register bit 0.
  - On `BaudTick`:
    - shift right and increment the counter;
    - after bit `DATA_BITS`-1, go to PARITY (if enabled) or STOP.
  - Counter width is `$clog2(DATA_BITS)`; it is cleared on STOP/IDLE entry.
- **PARITY**
  - `TxOut` = XOR of the captured data, XOR `ParityType`.
  - On `BaudTick`: go to STOP.
- **STOP**
  - `TxOut`=1.
  - On the `STOP_BITS`-th `BaudTick` in this state:
    - go to IDLE;
    - assert `DoneFlag` for exactly that cycle.
- **Busy**
  - `Busy`=1 in every state except IDLE.
  - A `Send` while Busy is ignored and not queued.
- **Back-to-back frames**
  - `Send` held high across `DoneFlag` starts the next frame on the next `BaudTick` seen in IDLE, never on the `DoneFlag` tick itself.
  - This guarantees the holding register has reloaded; minimum inter-frame gap is one bit period of idle-high.
- **DataIn stability**
  - Changes to `DataIn` during a frame have no effect; only the captured copy is transmitted.
- **Reset**
  - `ResetN` low at any time (including mid-frame) forces IDLE, `TxOut`=1, `Busy`=0, `DoneFlag`=0, counters and shift register 0, immediately without waiting for `Clock`.
  - After deassertion, the block waits for a fresh `Send`+`BaudTick`.

## Timing
- All outputs are registered; no combinational path from input to output.
- `TxOut`, `Busy` change one `Clock` after the qualifying `BaudTick` edge.
- Frame length in ticks = 1 + `DATA_BITS` + P + `STOP_BITS` (P = 1 with parity, else 0). Default with parity: 11 ticks.
- `DoneFlag` is high for exactly one `Clock`, coincident with `Busy` falling.
- `BaudTick` asserted for more than one consecutive cycle is treated as one tick per cycle. Single-cycle pulses are required, not checked.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- **Defined**
  - PARITY state is present between DATA and STOP.
  - `ParityType` selects even/odd as above.
- **Undefined**
  - PARITY state is absent; DATA goes directly to STOP.
  - `ParityType` port remains for interface stability but is ignored.
  - Frame length drops by one tick.

## Test plan
- **Reset and idle:** reset, then idle 20 ticks with `Send`=0 → `TxOut`=1, `Busy`=0, `DoneFlag`=0 throughout.
- **Even parity, 0xA5:** `DataIn`=0xA5, `ParityType`=0, `Send` on a tick, parity enabled → `TxOut` per tick 0,1,0,1,0,0,1,0,1,0,1; `DoneFlag` single pulse at tick 11.
- **Odd parity, same word:** `ParityType`=1 → parity bit 1. `STOP_BITS`=2 → two stop ticks; `DoneFlag` at tick 12.
- **Ignored request and stable data:** `Send` pulsed mid-frame and `DataIn` changed to 0x3C mid-frame → no extra frame; transmitted bits still 0xA5.
- **Back-to-back:** `Send` held high over two frames → second start bit exactly one idle tick after `DoneFlag`; second frame carries `DataIn` as reloaded at `DoneFlag`.
- **Reset mid-frame:** `ResetN` low during DATA bit 3 → `TxOut`=1, `Busy`=0 immediately. After release, the next `Send`+tick produces a complete, correct frame for 0xFF.
